// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

  localparam int DEF_TIMEOUT      = 16;
  localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the arbiter's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_wait;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              mem_wait;

  logic              bus_err;

  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ack,
    output if_rdata, if_valid, if_wait, mem_rdata, mem_valid, mem_wait, bus_err,
           ram_req, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ack,
    input  if_rdata, if_valid, if_wait, mem_rdata, mem_valid, mem_wait, bus_err,
           ram_req, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_arb_timeout.sv
// BUSY-cycle counter; o_expired flags the last permitted cycle (count TIMEOUT-1).
module mem_arb_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_at_limit;

  assign w_at_limit = (r_cnt == CW'(TIMEOUT - 1));
  assign o_expired  = i_en & w_at_limit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_limit) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF and MEM (MEM has priority).
// Optional IF anti-starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  arb_state_e        r_state, w_state_nxt;
  gnt_e              r_gnt, w_gnt_nxt;
  logic              w_grant;
  logic              w_if_wins;
  logic              w_tmo_clr, w_tmo_en, w_expired;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_err;
  logic [DATA_W-1:0] r_if_rdata, r_mem_rdata;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;
  logic          w_starved;

  assign w_starved = (r_starve == SW'(STARVE_LIMIT));
  assign w_if_wins = bus.if_req & (~bus.mem_req | w_starved);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= '0;
    end else if (w_grant) begin
      if (w_gnt_nxt == GNT_IF) begin
        r_starve <= '0;
      end else if (bus.if_req && !w_starved) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end
`else
  assign w_if_wins = bus.if_req & ~bus.mem_req;
`endif

  mem_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_tmo_clr),
    .i_en      (w_tmo_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_gnt   <= GNT_IF;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_grant     = 1'b0;
    w_tmo_clr   = 1'b0;
    w_tmo_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.if_req || bus.mem_req) begin
          w_grant     = 1'b1;
          w_tmo_clr   = 1'b1;
          w_gnt_nxt   = w_if_wins ? GNT_IF : GNT_MEM;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_tmo_en = 1'b1;
        if (bus.ram_ack || w_expired) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // An ack in the expiry cycle takes precedence, so the error flag is only set without one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_err <= 1'b0;
        if (w_gnt_nxt == GNT_MEM) begin
          r_addr  <= bus.mem_addr;
          r_wdata <= bus.mem_wdata;
          r_we    <= bus.mem_we;
        end else begin
          r_addr  <= bus.if_addr;
          r_wdata <= '0;
          r_we    <= 1'b0;
        end
      end
      if (r_state == ST_BUSY) begin
        if (bus.ram_ack) begin
          if (!r_we) begin
            if (r_gnt == GNT_MEM) r_mem_rdata <= bus.ram_rdata;
            else                  r_if_rdata  <= bus.ram_rdata;
          end
        end else if (w_expired) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign bus.ram_req   = (r_state == ST_BUSY);
  assign bus.ram_we    = bus.ram_req & r_we;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;

  assign bus.if_valid  = (r_state == ST_DONE) && (r_gnt == GNT_IF);
  assign bus.mem_valid = (r_state == ST_DONE) && (r_gnt == GNT_MEM);
  assign bus.bus_err   = (r_state == ST_DONE) && r_err;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.if_wait   = bus.if_req & ~bus.if_valid;
  assign bus.mem_wait  = bus.mem_req & ~bus.mem_valid;

endmodule
